// File: rtl/regfile_port_arbiter_pkg.sv
// rtl/regfile_port_arbiter_pkg.sv - shared op constants, FSM states and op classifier
package regfile_port_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int N_REG          = 16;

    localparam logic [7:0]  OP_READ    = 8'h22;
    localparam logic [7:0]  OP_WRITE   = 8'h21;
    localparam logic [3:0]  OP_ALU_NIB = 4'h1;
    localparam logic [15:0] OP_NOP     = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OPC_ILLEGAL = 2'd0,
        OPC_ALU     = 2'd1,
        OPC_READ    = 2'd2,
        OPC_WRITE   = 2'd3
    } op_class_t;

    // Decode the top byte/nibble of an op word into its class.
    function automatic op_class_t classify_op(input logic [15:0] op);
        if (op[15:12] == OP_ALU_NIB)     return OPC_ALU;
        else if (op[15:8] == OP_READ)    return OPC_READ;
        else if (op[15:8] == OP_WRITE)   return OPC_WRITE;
        else                             return OPC_ILLEGAL;
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter_2.sv
// rtl/regfile_port_arbiter_rr_arbiter_2.sv - two-way round-robin arbiter with host lock override
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_lock,
    input  logic       i_accept,
    output logic       o_gnt_valid,
    output logic       o_gnt_id
);

    logic r_last;

    // Pick the winner: host lock first, then alternate on contention.
    always_comb begin
        o_gnt_valid = |i_req;
        o_gnt_id    = 1'b0;
        if (i_lock && r_last && i_req[1]) begin
            o_gnt_id = 1'b1;
        end else if (i_req == 2'b11) begin
            o_gnt_id = ~r_last;
        end else if (i_req[1]) begin
            o_gnt_id = 1'b1;
        end
    end

    // Remember who won the last accepted request; reset favours requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= o_gnt_id;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - arbitrates two requesters onto one register file port
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = $clog2(N_REG)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][DATA_WIDTH-1:0] req_op,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr_1,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr_2,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr_3,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
    input  logic                       req_lock_1,
    output logic [DATA_WIDTH-1:0]      rf_op,
    output logic [ADDR_WIDTH-1:0]      rf_addr_1,
    output logic [ADDR_WIDTH-1:0]      rf_addr_2,
    output logic [ADDR_WIDTH-1:0]      rf_addr_3,
    output logic [DATA_WIDTH-1:0]      rf_write_data,
    input  logic [DATA_WIDTH-1:0]      rf_read_data_1,
    input  logic [DATA_WIDTH-1:0]      rf_read_data_2,
    input  logic [DATA_WIDTH-1:0]      rf_read_data_reg,
    input  logic [DATA_WIDTH-1:0]      alu_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic                       rsp_err,
    output logic [DATA_WIDTH-1:0]      rsp_rdata_1,
    output logic [DATA_WIDTH-1:0]      rsp_rdata_2,
    output logic [DATA_WIDTH-1:0]      rsp_rdata_reg,
    output logic                       busy,
    output logic [15:0]                ops_done
);

    state_t                r_state;
    state_t                w_state_nxt;
    op_class_t             r_class;
    logic                  r_id;
    logic [DATA_WIDTH-1:0] r_op;
    logic [ADDR_WIDTH-1:0] r_addr_1;
    logic [ADDR_WIDTH-1:0] r_addr_2;
    logic [ADDR_WIDTH-1:0] r_addr_3;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata_1;
    logic [DATA_WIDTH-1:0] r_rdata_2;
    logic [DATA_WIDTH-1:0] r_rdata_reg;
    logic [15:0]           r_ops_done;

    logic                  w_gnt_valid;
    logic                  w_gnt_id;
    logic                  w_accept;
    logic                  w_rsp_done;

    rr_arbiter_2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (req_valid),
        .i_lock      (req_lock_1),
        .i_accept    (w_accept),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus all handshake and register-file drive outputs.
    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = 2'b00;
        w_accept      = 1'b0;
        w_rsp_done    = 1'b0;
        rf_op         = DATA_WIDTH'(OP_NOP);
        rf_addr_1     = '0;
        rf_addr_2     = '0;
        rf_addr_3     = '0;
        rf_write_data = '0;
        rsp_valid     = 1'b0;
        rsp_err       = 1'b0;
        busy          = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid && !reset) begin
                    req_ready[w_gnt_id] = 1'b1;
                end
                w_accept = |(req_valid & req_ready);
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_class != OPC_ILLEGAL) begin
                    rf_op     = r_op;
                    rf_addr_1 = r_addr_1;
                    rf_addr_2 = r_addr_2;
                    rf_addr_3 = r_addr_3;
                    if (r_class == OPC_ALU) begin
                        rf_write_data = alu_result;
                    end else if (r_class == OPC_WRITE) begin
                        rf_write_data = r_wdata;
                    end
                end
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid  = 1'b1;
                rsp_err    = (r_class == OPC_ILLEGAL);
                w_rsp_done = rsp_ready;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the winning request on accept and capture read data at the end of issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_class     <= OPC_ILLEGAL;
            r_id        <= 1'b0;
            r_op        <= '0;
            r_addr_1    <= '0;
            r_addr_2    <= '0;
            r_addr_3    <= '0;
            r_wdata     <= '0;
            r_rdata_1   <= '0;
            r_rdata_2   <= '0;
            r_rdata_reg <= '0;
        end else if (w_accept) begin
            r_class  <= classify_op(req_op[w_gnt_id][15:0]);
            r_id     <= w_gnt_id;
            r_op     <= req_op[w_gnt_id];
            r_addr_1 <= req_addr_1[w_gnt_id];
            r_addr_2 <= req_addr_2[w_gnt_id];
            r_addr_3 <= req_addr_3[w_gnt_id];
            r_wdata  <= req_wdata[w_gnt_id];
        end else if (r_state == ST_ISSUE) begin
            if (r_class == OPC_ILLEGAL) begin
                r_rdata_1   <= '0;
                r_rdata_2   <= '0;
                r_rdata_reg <= '0;
            end else begin
                r_rdata_1   <= rf_read_data_1;
                r_rdata_2   <= rf_read_data_2;
                r_rdata_reg <= rf_read_data_reg;
            end
        end
    end

    // Count completed responses; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ops_done <= 16'h0000;
        end else if (w_rsp_done) begin
            r_ops_done <= r_ops_done + 16'h0001;
        end
    end

    assign rsp_id        = r_id;
    assign rsp_rdata_1   = r_rdata_1;
    assign rsp_rdata_2   = r_rdata_2;
    assign rsp_rdata_reg = r_rdata_reg;
    assign ops_done      = r_ops_done;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - directed self-checking bench for regfile_port_arbiter
module tb_regfile_port_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][15:0] req_op;
    logic [1:0][3:0]  req_addr_1;
    logic [1:0][3:0]  req_addr_2;
    logic [1:0][3:0]  req_addr_3;
    logic [1:0][15:0] req_wdata;
    logic             req_lock_1;
    logic [15:0]      rf_op;
    logic [3:0]       rf_addr_1;
    logic [3:0]       rf_addr_2;
    logic [3:0]       rf_addr_3;
    logic [15:0]      rf_write_data;
    logic [15:0]      rf_read_data_1;
    logic [15:0]      rf_read_data_2;
    logic [15:0]      rf_read_data_reg;
    logic [15:0]      alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic             rsp_err;
    logic [15:0]      rsp_rdata_1;
    logic [15:0]      rsp_rdata_2;
    logic [15:0]      rsp_rdata_reg;
    logic             busy;
    logic [15:0]      ops_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr_1       (req_addr_1),
        .req_addr_2       (req_addr_2),
        .req_addr_3       (req_addr_3),
        .req_wdata        (req_wdata),
        .req_lock_1       (req_lock_1),
        .rf_op            (rf_op),
        .rf_addr_1        (rf_addr_1),
        .rf_addr_2        (rf_addr_2),
        .rf_addr_3        (rf_addr_3),
        .rf_write_data    (rf_write_data),
        .rf_read_data_1   (rf_read_data_1),
        .rf_read_data_2   (rf_read_data_2),
        .rf_read_data_reg (rf_read_data_reg),
        .alu_result       (alu_result),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_err          (rsp_err),
        .rsp_rdata_1      (rsp_rdata_1),
        .rsp_rdata_2      (rsp_rdata_2),
        .rsp_rdata_reg    (rsp_rdata_reg),
        .busy             (busy),
        .ops_done         (ops_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_lock_1 = 1'b0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait (bounded) for a response handshake seen at a negedge; returns its id.
    task automatic wait_hs(input string tag, output logic id);
        logic ok;
        ok = 1'b0;
        id = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid && rsp_ready) begin
                ok = 1'b1;
                id = rsp_id;
            end
        end
        chk({tag, "_hs_seen"}, {31'd0, ok}, 32'd1);
    endtask

    logic       id;
    logic [1:0] exp_rr [4];

    initial begin
        reset            = 1'b1;
        req_valid        = 2'b11;
        req_lock_1       = 1'b0;
        rsp_ready        = 1'b0;
        req_op           = '0;
        req_addr_1       = '0;
        req_addr_2       = '0;
        req_addr_3       = '0;
        req_wdata        = '0;
        rf_read_data_1   = 16'h0000;
        rf_read_data_2   = 16'h0000;
        rf_read_data_reg = 16'h0000;
        alu_result       = 16'h0000;

        // Reset state, with requests pending
        #3;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_ops_done",  {16'd0, ops_done},  32'd0);
        chk("rst_rf_op",     {16'd0, rf_op},     32'd0);
        do_reset();

        // WRITE from requester 0
        req_valid     = 2'b01;
        req_op[0]     = 16'h2100;
        req_addr_3[0] = 4'd5;
        req_wdata[0]  = 16'hBEEF;
        #1;
        chk("wr_req_ready", {30'd0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("wr_rf_op",    {16'd0, rf_op},         32'h2100);
        chk("wr_rf_wdata", {16'd0, rf_write_data}, 32'hBEEF);
        chk("wr_rf_addr3", {28'd0, rf_addr_3},     32'd5);
        chk("wr_issue_rv", {30'd0, busy, rsp_valid}, 32'h2);
        @(negedge clk);
        #1;
        chk("wr_rsp", {29'd0, rsp_valid, rsp_id, rsp_err}, 32'h4);
        chk("wr_resp_rf_op", {16'd0, rf_op}, 32'h0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("wr_ops_done", {16'd0, ops_done}, 32'd1);
        chk("wr_idle", {30'd0, busy, rsp_valid}, 32'h0);

        // ALU op from requester 1
        req_valid      = 2'b10;
        req_op[1]      = 16'h1123;
        alu_result     = 16'h0042;
        rf_read_data_1 = 16'h0007;
        #1;
        chk("alu_req_ready", {30'd0, req_ready}, 32'h2);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("alu_rf_wdata", {16'd0, rf_write_data}, 32'h0042);
        @(negedge clk);
        #1;
        chk("alu_rdata1", {16'd0, rsp_rdata_1}, 32'h0007);
        chk("alu_rsp_id", {31'd0, rsp_id}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Illegal op with backpressure on the response
        req_valid        = 2'b01;
        req_op[0]        = 16'h3000;
        rf_read_data_reg = 16'h1234;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("ill_rf_op",    {16'd0, rf_op},         32'h0);
        chk("ill_rf_wdata", {16'd0, rf_write_data}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("ill_hold", {rsp_valid, rsp_err, rsp_id, 13'd0, rsp_rdata_1 | rsp_rdata_reg},
                32'hC000_0000);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("ill_ops_done", {16'd0, ops_done}, 32'd3);

        // Round-robin with both requesters valid
        do_reset();
        req_op[0] = 16'h2200;
        req_op[1] = 16'h2200;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        exp_rr = '{2'd0, 2'd1, 2'd0, 2'd1};
        for (int i = 0; i < 4; i++) begin
            wait_hs("rr", id);
            chk("rr_grant", {31'd0, id}, {30'd0, exp_rr[i]});
        end
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("rr_ops_done", {16'd0, ops_done}, 32'd4);

        // Host lock holds the grant on requester 1
        do_reset();
        rsp_ready  = 1'b1;
        req_lock_1 = 1'b1;
        req_valid  = 2'b10;
        wait_hs("lk0", id);
        chk("lk_first", {31'd0, id}, 32'd1);
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            wait_hs("lk", id);
            chk("lk_hold", {31'd0, id}, 32'd1);
        end
        req_lock_1 = 1'b0;
        wait_hs("lk_rel", id);
        chk("lk_release", {31'd0, id}, 32'd0);
        req_valid = 2'b00;

        // Counter wrap 0xFFFF -> 0x0000
        do_reset();
        force dut.r_ops_done = 16'hFFFE;
        #1;
        release dut.r_ops_done;
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        wait_hs("wr1", id);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("wrap_ffff", {16'd0, ops_done}, 32'h0000_FFFF);
        req_valid = 2'b01;
        wait_hs("wr2", id);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("wrap_zero", {16'd0, ops_done}, 32'h0);

        // Reset asserted mid-RESP aborts silently
        do_reset();
        force dut.r_ops_done = 16'hFFFF;
        #1;
        release dut.r_ops_done;
        rf_read_data_1 = 16'h0055;
        req_valid      = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("ab_in_resp", {15'd0, rsp_valid, rsp_id, rsp_rdata_1}, 32'h0003_0055);
        #1;
        reset = 1'b1;
        #1;
        chk("ab_rsp",  {29'd0, rsp_valid, rsp_id, rsp_err}, 32'd0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_ops",  {16'd0, ops_done}, 32'd0);
        chk("ab_data", {rsp_rdata_1, rsp_rdata_reg}, 32'd0);
        chk("ab_rf",   {rf_op, rf_write_data}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("ab_silent", {15'd0, rsp_valid, ops_done}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
